// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and clock constant for the period meter
package period_meter_pkg;

    localparam int CLK_HZ = 12000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// sync_edge_detect: synchronizes an async input and emits registered rise/fall pulses
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end

    assign w_s   = r_sync[SYNC_STAGES-1];
    assign level = r_s_d;
    assign rise  = r_rise;
    assign fall  = r_fall;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_s_d  <= w_s;
            r_rise <= w_s & ~r_s_d;
            r_fall <= ~w_s & r_s_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow input in clkin cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = CLK_HZ,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             sigin,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || TIMEOUT >= 2**CNT_W) begin : g_bad_timeout
        $error("TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_stage;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_hi_seen;
    logic             r_valid;
    logic             r_timeout;
    logic             r_busy;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_unused_level;
    logic             w_rise;
    logic             w_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (sigin),
        .level (w_unused_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign busy      = r_busy;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hi_stage <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_hi_seen  <= 1'b0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!enable) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_hi_seen <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                    ST_WAIT: begin
                        if (w_rise) begin
                            r_state   <= ST_MEAS;
                            r_cnt     <= '0;
                            r_hi_seen <= 1'b0;
                        end
                    end
                    ST_MEAS: begin
                        // a rise on the last counted cycle still closes a valid period
                        if (w_rise) begin
                            r_period  <= w_cnt_inc;
                            r_high    <= r_hi_seen ? r_hi_stage : w_cnt_inc;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_cnt     <= '0;
                            r_hi_seen <= 1'b0;
                        end else if (r_cnt == TO_LAST) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_WAIT;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_fall && !r_hi_seen) begin
                                r_hi_stage <= w_cnt_inc;
                                r_hi_seen  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
